// File: rtl/trdb_packet_serializer.sv
// Trace packet serializer: buffers assembled packets in a FIFO and emits each one,
// prefixed by a 2-byte header {L, {4'b0, format, subformat}}, as fixed-width beats.
module trdb_packet_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 32,
  parameter int unsigned OUT_BYTES     = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DROP_ON_FULL  = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             packet_valid_i,
  output logic                             packet_ready_o,
  input  logic [1:0]                       packet_format_i,
  input  logic [1:0]                       packet_subformat_i,
  input  logic [7:0]                       packet_length_i,
  input  logic [8*PAYLOAD_BYTES-1:0]       packet_payload_i,
  output logic                             beat_valid_o,
  input  logic                             beat_ready_i,
  output logic [8*OUT_BYTES-1:0]           beat_data_o,
  output logic [$clog2(OUT_BYTES+1)-1:0]   beat_bytes_o,
  output logic                             beat_last_o,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_count_o,
  output logic [7:0]                       drop_cnt_o,
  output logic                             busy_o
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;
  localparam int unsigned OW = 8 * OUT_BYTES;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(OUT_BYTES + 1);
  // Stream register is padded to a whole number of beats so the tail reads as zero.
  localparam int unsigned SB = ((PAYLOAD_BYTES + 2 + OUT_BYTES - 1) / OUT_BYTES) * OUT_BYTES;
  localparam int unsigned SW = 8 * SB;
  localparam logic [15:0] OB = 16'(OUT_BYTES);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [1:0]    r_fmt_mem [DEPTH];
  logic [1:0]    r_sub_mem [DEPTH];
  logic [7:0]    r_len_mem [DEPTH];
  logic [PW-1:0] r_pay_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop_cnt;

  state_e        r_state;
  logic [SW-1:0] r_stream;
  logic [15:0]   r_remain;
  logic [BW-1:0] r_beat_bytes;
  logic          r_beat_last;

  logic          w_full, w_empty, w_push, w_pop, w_drop;
  logic [7:0]    w_len_clamped;
  logic [PW-1:0] w_pay_masked;
  logic [SW-1:0] w_head_stream, w_stream_next;
  logic [15:0]   w_head_total, w_rem_next;
  logic [BW-1:0] w_bytes_next;
  logic          w_last_next;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends on registered occupancy only; a same-cycle pop never frees a slot.
  assign packet_ready_o = (DROP_ON_FULL != 0) ? 1'b1 : !w_full;
  assign w_push = packet_valid_i & packet_ready_o & !w_full;
  assign w_drop = packet_valid_i & w_full & (DROP_ON_FULL != 0);

  assign w_pop = !w_empty & ((r_state == StIdle) |
                             ((r_state == StSend) & beat_ready_i & r_beat_last));

  assign w_len_clamped = (packet_length_i > 8'(PAYLOAD_BYTES)) ? 8'(PAYLOAD_BYTES)
                                                                : packet_length_i;

  // Bytes past the effective length are stored as zero so the beat tail is clean.
  always_comb begin
    w_pay_masked = '0;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (8'(k) < w_len_clamped) w_pay_masked[8*k +: 8] = packet_payload_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fmt_mem[r_wr_ptr] <= packet_format_i;
      r_sub_mem[r_wr_ptr] <= packet_subformat_i;
      r_len_mem[r_wr_ptr] <= w_len_clamped;
      r_pay_mem[r_wr_ptr] <= w_pay_masked;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_comb begin
    w_head_stream        = '0;
    w_head_stream[7:0]   = r_len_mem[r_rd_ptr];
    w_head_stream[15:8]  = {4'b0000, r_fmt_mem[r_rd_ptr], r_sub_mem[r_rd_ptr]};
    w_head_stream[16 +: PW] = r_pay_mem[r_rd_ptr];
    w_head_total         = {8'h00, r_len_mem[r_rd_ptr]} + 16'd2;
  end

  always_comb begin
    w_stream_next = r_stream >> OW;
    w_rem_next    = r_remain - OB;
    if (w_pop) begin
      w_stream_next = w_head_stream;
      w_rem_next    = w_head_total;
    end
    w_bytes_next = (w_rem_next >= OB) ? BW'(OUT_BYTES) : BW'(w_rem_next);
    w_last_next  = (w_rem_next <= OB);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_stream     <= '0;
      r_remain     <= '0;
      r_beat_bytes <= '0;
      r_beat_last  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_state      <= StSend;
            r_stream     <= w_stream_next;
            r_remain     <= w_rem_next;
            r_beat_bytes <= w_bytes_next;
            r_beat_last  <= w_last_next;
          end
        end
        StSend: begin
          if (beat_ready_i) begin
            if (!r_beat_last || w_pop) begin
              r_stream     <= w_stream_next;
              r_remain     <= w_rem_next;
              r_beat_bytes <= w_bytes_next;
              r_beat_last  <= w_last_next;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign beat_valid_o = (r_state == StSend);
  assign beat_data_o  = r_stream[OW-1:0];
  assign beat_bytes_o = r_beat_bytes;
  assign beat_last_o  = r_beat_last;
  assign fifo_count_o = r_count;
  assign drop_cnt_o   = r_drop_cnt;
  assign busy_o       = !w_empty | (r_state == StSend);

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// Directed bench for trdb_packet_serializer: a lossless and a lossy instance, each with a
// scoreboard of expected beats built from an independent byte-stream model.
module tb_trdb_packet_serializer;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         va, vb;
  logic [1:0]   pfmt, psub;
  logic [7:0]   plen;
  logic [255:0] ppay;

  logic a_pready, a_valid, a_bready, a_last, a_busy;
  logic [31:0] a_data;
  logic [2:0]  a_bytes, a_count;
  logic [7:0]  a_drop;
  logic b_pready, b_valid, b_bready, b_last, b_busy;
  logic [31:0] b_data;
  logic [2:0]  b_bytes, b_count;
  logic [7:0]  b_drop;

  int n_cmp = 0;
  int n_fail = 0;
  int n_beats_a = 0;
  beat_t q_a[$];
  beat_t q_b[$];

  always #5 clk = ~clk;

  trdb_packet_serializer #(
    .PAYLOAD_BYTES(32), .OUT_BYTES(4), .DEPTH(4), .DROP_ON_FULL(0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .packet_valid_i(va), .packet_ready_o(a_pready),
    .packet_format_i(pfmt), .packet_subformat_i(psub),
    .packet_length_i(plen), .packet_payload_i(ppay),
    .beat_valid_o(a_valid), .beat_ready_i(a_bready), .beat_data_o(a_data),
    .beat_bytes_o(a_bytes), .beat_last_o(a_last), .fifo_count_o(a_count),
    .drop_cnt_o(a_drop), .busy_o(a_busy)
  );

  trdb_packet_serializer #(
    .PAYLOAD_BYTES(32), .OUT_BYTES(4), .DEPTH(4), .DROP_ON_FULL(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .packet_valid_i(vb), .packet_ready_o(b_pready),
    .packet_format_i(pfmt), .packet_subformat_i(psub),
    .packet_length_i(plen), .packet_payload_i(ppay),
    .beat_valid_o(b_valid), .beat_ready_i(b_bready), .beat_data_o(b_data),
    .beat_bytes_o(b_bytes), .beat_last_o(b_last), .fifo_count_o(b_count),
    .drop_cnt_o(b_drop), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats from the byte-stream definition: L, header, payload, zero pad.
  task automatic model_push(input bit sel, input logic [1:0] f, input logic [1:0] s,
                            input logic [7:0] len, input logic [255:0] p);
    int l, t, idx;
    beat_t e;
    logic [7:0] bv;
    l = (len > 8'd32) ? 32 : int'(len);
    t = l + 2;
    for (int b = 0; b * 4 < t; b++) begin
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
        idx = b * 4 + k;
        if (idx == 0)      bv = 8'(l);
        else if (idx == 1) bv = {4'b0000, f, s};
        else if (idx < t)  bv = p[8*(idx-2) +: 8];
        else               bv = 8'h00;
        e.data[8*k +: 8] = bv;
      end
      e.bytes = (t - b * 4 >= 4) ? 3'd4 : 3'(t - b * 4);
      e.last  = (b * 4 + 4 >= t);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endtask

  function automatic logic [255:0] rnd_pay();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && a_valid && a_bready) begin
      beat_t e;
      n_cmp++;
      assert (q_a.size() != 0) else begin
        n_fail++;
        $error("FAIL a_unexpected_beat: observed data %0h expected no beat", a_data);
      end
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_beat_data", a_data, e.data);
        chk("a_beat_bytes", a_bytes, e.bytes);
        chk("a_beat_last", a_last, e.last);
      end
      n_beats_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_valid && b_bready) begin
      beat_t e;
      n_cmp++;
      assert (q_b.size() != 0) else begin
        n_fail++;
        $error("FAIL b_unexpected_beat: observed data %0h expected no beat", b_data);
      end
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_beat_data", b_data, e.data);
        chk("b_beat_bytes", b_bytes, e.bytes);
        chk("b_beat_last", b_last, e.last);
      end
    end
  end

  task automatic drive(input logic [1:0] f, input logic [1:0] s, input logic [7:0] l,
                       input logic [255:0] p);
    pfmt = f; psub = s; plen = l; ppay = p;
  endtask

  // Offer a packet to A until accepted; returns just after the accepting edge.
  task automatic push_a(input logic [1:0] f, input logic [1:0] s, input logic [7:0] l,
                        input logic [255:0] p, input bit use_model);
    int n = 0;
    drive(f, s, l, p);
    va = 1'b1;
    @(negedge clk);
    while (!a_pready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_push_accept", a_pready, 1'b1);
    if (a_pready && use_model) model_push(1'b0, f, s, l, p);
    @(posedge clk);
    #1 va = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] f, input logic [1:0] s, input logic [7:0] l,
                        input logic [255:0] p, input bit expect_kept);
    drive(f, s, l, p);
    vb = 1'b1;
    @(negedge clk);
    chk("b_ready_high", b_pready, 1'b1);
    if (expect_kept) model_push(1'b1, f, s, l, p);
    @(posedge clk);
    #1 vb = 1'b0;
  endtask

  task automatic wait_valid_a();
    int n = 0;
    @(negedge clk);
    while (!a_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_valid_wait", a_valid, 1'b1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while ((a_busy || a_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_busy", a_busy, 1'b0);
    chk("a_sb_drained", q_a.size(), 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    @(negedge clk);
    while ((b_busy || b_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_busy", b_busy, 1'b0);
    chk("b_sb_drained", q_b.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; va = 1'b0; vb = 1'b0; a_bready = 1'b0; b_bready = 1'b0;
    drive(2'd0, 2'd0, 8'd0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_pready, 1'b1);
    chk("rst_b_ready", b_pready, 1'b1);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_a_bytes", a_bytes, 3'd0);
    chk("rst_a_last", a_last, 1'b0);
    chk("rst_a_count", a_count, 3'd0);
    chk("rst_a_drop", a_drop, 8'd0);
    chk("rst_a_busy", a_busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic packet with literal expected beats and 2-cycle latency.
    a_bready = 1'b1;
    q_a.push_back('{32'h12110805, 3'd4, 1'b0});
    q_a.push_back('{32'h00151413, 3'd3, 1'b1});
    push_a(2'd2, 2'd0, 8'd5, 256'h15_14_13_12_11, 1'b0);
    @(negedge clk);
    chk("lat_n1_valid", a_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_valid", a_valid, 1'b1);
    wait_idle_a();

    // Backpressure on beat 0 for three cycles.
    @(posedge clk); #1;
    a_bready = 1'b0;
    push_a(2'd2, 2'd0, 8'd5, 256'h15_14_13_12_11, 1'b1);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", a_valid, 1'b1);
      chk("bp_data", a_data, 32'h12110805);
      chk("bp_bytes", a_bytes, 3'd4);
      chk("bp_last", a_last, 1'b0);
      @(posedge clk);
    end
    #1 a_bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_beat1_valid", a_valid, 1'b1);
    chk("bp_beat1_data", a_data, 32'h00151413);
    wait_idle_a();

    // Lossless fill: five accepted, sixth stalls with ready low.
    @(posedge clk); #1;
    a_bready = 1'b0;
    for (int i = 0; i < 5; i++) push_a(2'(i), 2'(3 - i), 8'(i + 1), rnd_pay(), 1'b1);
    drive(2'd1, 2'd1, 8'd6, rnd_pay());
    va = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("fill_ready_low", a_pready, 1'b0);
      chk("fill_count", a_count, 3'd4);
      chk("fill_drop", a_drop, 8'd0);
    end
    @(posedge clk); #1;
    a_bready = 1'b1;
    push_a(pfmt, psub, plen, ppay, 1'b1);
    wait_idle_a();

    // Back-to-back single-beat packets.
    @(posedge clk); #1;
    push_a(2'd1, 2'd2, 8'd2, rnd_pay(), 1'b1);
    push_a(2'd3, 2'd1, 8'd2, rnd_pay(), 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("b2b_valid", a_valid, 1'b1);
      chk("b2b_bytes", a_bytes, 3'd4);
      chk("b2b_last", a_last, 1'b1);
    end
    @(negedge clk);
    chk("b2b_after_valid", a_valid, 1'b0);
    wait_idle_a();

    // Lossy overflow: seven offered, last two dropped.
    @(posedge clk); #1;
    b_bready = 1'b0;
    for (int i = 0; i < 7; i++) push_b(2'(i), 2'(i + 1), 8'(3 * i), rnd_pay(), i < 5);
    @(negedge clk);
    chk("lossy_drop", b_drop, 8'd2);
    chk("lossy_count", b_count, 3'd4);
    chk("lossy_ready", b_pready, 1'b1);
    @(posedge clk); #1;
    b_bready = 1'b1;
    wait_idle_b();

    // Reset during beat 1 of an L=9 packet, then clamp L=40 to 32.
    @(posedge clk); #1;
    a_bready = 1'b0;
    push_a(2'd0, 2'd1, 8'd9, rnd_pay(), 1'b1);
    wait_valid_a();
    @(posedge clk); #1 a_bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 a_bready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_valid, 1'b0);
    chk("mid_rst_data", a_data, 32'h0);
    chk("mid_rst_bytes", a_bytes, 3'd0);
    chk("mid_rst_last", a_last, 1'b0);
    chk("mid_rst_count", a_count, 3'd0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_b_drop", b_drop, 8'd0);
    q_a.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_beats_a = 0;
    a_bready = 1'b1;
    push_a(2'd3, 2'd3, 8'd40, rnd_pay(), 1'b1);
    wait_valid_a();
    chk("clamp_hdr_len", a_data[7:0], 8'h20);
    wait_idle_a();
    chk("clamp_beats", n_beats_a, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
